// File: rtl/demux_1x4_deser.sv
// rtl/demux_1x4_deser.sv - registered 1-to-4 demux/deserializer; optional overrun flag via DEMUX_OVERRUN_EN
module demux_1x4_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             sel_mode,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       lane_valid,
  output logic             frame_valid,
`ifdef DEMUX_OVERRUN_EN
  output logic             overrun,
`endif
  input  logic             frame_ready
);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] y_q [4];
  logic [WIDTH-1:0] y_d [4];
  logic [3:0]       lane_valid_q, lane_valid_d;
  logic             frame_valid_q, frame_valid_d;
  logic [1:0]       lane;
  logic             accept;

  assign din_ready = (state_q == ST_FILL);
  assign accept    = din_valid & din_ready;
  assign lane      = sel_mode ? sel : ptr_q;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    y_d           = y_q;
    lane_valid_d  = lane_valid_q;
    frame_valid_d = frame_valid_q;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          y_d[lane]    = din;
          lane_valid_d = lane_valid_q | (4'b0001 << lane);
          if (!sel_mode) begin
            ptr_d = ptr_q + 2'd1;
          end
          // Completing lane and frame_valid land on the same edge.
          if (lane_valid_d == 4'hF) begin
            state_d       = ST_FULL;
            frame_valid_d = 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (frame_ready) begin
          state_d       = ST_FILL;
          ptr_d         = 2'd0;
          lane_valid_d  = 4'h0;
          frame_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FILL;
      ptr_q         <= 2'd0;
      lane_valid_q  <= 4'h0;
      frame_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        y_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      lane_valid_q  <= lane_valid_d;
      frame_valid_q <= frame_valid_d;
      y_q           <= y_d;
    end
  end

`ifdef DEMUX_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Sticky: only rst_n clears it.
  always_comb begin
    overrun_d = overrun_q | (din_valid & ~din_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`endif

  assign y0          = y_q[0];
  assign y1          = y_q[1];
  assign y2          = y_q[2];
  assign y3          = y_q[3];
  assign lane_valid  = lane_valid_q;
  assign frame_valid = frame_valid_q;

endmodule
